// File: rtl/sys_int_regs.sv
// sys_int_regs: local-bus register block with interrupt aggregation and an
// optional heartbeat watchdog.
// Optional feature macro: SYS_INT_REGS_HB_WDT_EN (defined -> watchdog present).
// Register map (word addresses):
//   0x00..0x03 version words (RO)   0x05 test (RW, reads inverted)
//   0x20 active (RO)   0x21 pending (W1C)   0x22 mask   0x23 mode (1=edge)
//   0x24 polarity (1=active-low)   0x25 bit0 global enable
//   0x28 kick (WO)   0x29 timeout   0x2A bit0 watchdog flag (W1C)
module sys_int_regs #(
  parameter int          INT_CH              = 4,
  parameter int          TICK_DIV            = 50000,
  parameter logic [15:0] LOGIC_VER_YEAR      = 16'h2020,
  parameter logic [15:0] LOGIC_VER_MONTH_DAY = 16'h0910,
  parameter logic [15:0] LOGIC_VER           = 16'h0400,
  parameter logic [15:0] DEBUG_VER           = 16'h0400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lbs_cs_n,
  input  logic              lbs_we,
  input  logic              lbs_re,
  input  logic [7:0]        lbs_addr,
  input  logic [15:0]       lbs_din,
  output logic [15:0]       lbs_dout,
  input  logic [INT_CH-1:0] irq_in,
  output logic              int_o,
  output logic              wdt_timeout
);

  localparam logic [7:0] ADDR_VER0  = 8'h00;
  localparam logic [7:0] ADDR_VER1  = 8'h01;
  localparam logic [7:0] ADDR_VER2  = 8'h02;
  localparam logic [7:0] ADDR_VER3  = 8'h03;
  localparam logic [7:0] ADDR_TEST  = 8'h05;
  localparam logic [7:0] ADDR_RAW   = 8'h20;
  localparam logic [7:0] ADDR_PEND  = 8'h21;
  localparam logic [7:0] ADDR_MASK  = 8'h22;
  localparam logic [7:0] ADDR_MODE  = 8'h23;
  localparam logic [7:0] ADDR_POL   = 8'h24;
  localparam logic [7:0] ADDR_EN    = 8'h25;
  localparam logic [7:0] ADDR_KICK  = 8'h28;
  localparam logic [7:0] ADDR_TOUT  = 8'h29;
  localparam logic [7:0] ADDR_WFLAG = 8'h2A;

  logic              wr_s;
  logic              rd_s;
  logic [15:0]       test_r;
  logic [INT_CH-1:0] mask_r;
  logic [INT_CH-1:0] mode_r;
  logic [INT_CH-1:0] pol_r;
  logic              en_r;
  logic [INT_CH-1:0] sync1_r;
  logic [INT_CH-1:0] sync2_r;
  logic [INT_CH-1:0] hist_r;
  logic [INT_CH-1:0] pend_r;
  logic [INT_CH-1:0] active_s;
  logic [INT_CH-1:0] set_s;
  logic [INT_CH-1:0] clr_s;
  logic [15:0]       rdata_s;

  assign wr_s = ~lbs_cs_n & lbs_we;
  assign rd_s = ~lbs_cs_n & lbs_re;

  // Synchronized input with polarity applied; the history sees this every cycle
  assign active_s = sync2_r ^ pol_r;

  // Edge channels set only on a rising active level, level channels while active
  assign set_s = (mode_r & active_s & ~hist_r) | (~mode_r & active_s);

  // Write-one-to-clear mask for the pending register
  always_comb begin
    clr_s = {INT_CH{1'b0}};
    if (wr_s && (lbs_addr == ADDR_PEND)) begin
      clr_s = lbs_din[INT_CH-1:0];
    end else begin
      clr_s = {INT_CH{1'b0}};
    end
  end

  // Two-flop synchronizer and edge-detector history for the interrupt inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {INT_CH{1'b0}};
      sync2_r <= {INT_CH{1'b0}};
      hist_r  <= {INT_CH{1'b0}};
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
      hist_r  <= active_s;
    end
  end

  // Pending latch: a new set beats a simultaneous write-one-to-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= {INT_CH{1'b0}};
    end else begin
      pend_r <= (pend_r & ~clr_s) | set_s;
    end
  end

  // Plain read/write configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_r <= 16'h0000;
      mask_r <= {INT_CH{1'b0}};
      mode_r <= {INT_CH{1'b0}};
      pol_r  <= {INT_CH{1'b0}};
      en_r   <= 1'b0;
    end else if (wr_s) begin
      case (lbs_addr)
        ADDR_TEST: test_r <= lbs_din;
        ADDR_MASK: mask_r <= lbs_din[INT_CH-1:0];
        ADDR_MODE: mode_r <= lbs_din[INT_CH-1:0];
        ADDR_POL:  pol_r  <= lbs_din[INT_CH-1:0];
        ADDR_EN:   en_r   <= lbs_din[0];
        default:   en_r   <= en_r;
      endcase
    end
  end

  // Aggregated interrupt, registered from the current pending/mask/enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_o <= 1'b0;
    end else begin
      int_o <= en_r & (|(pend_r & mask_r));
    end
  end

`ifdef SYS_INT_REGS_HB_WDT_EN
  localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_r;
  logic [15:0]   hb_r;
  logic [15:0]   tout_r;
  logic          flag_r;
  logic          tick_s;
  logic          kick_s;
  logic          tout_wr_s;
  logic          flag_clr_s;
  logic          flag_set_s;

  assign tick_s     = (presc_r == PRESC_MAX);
  assign kick_s     = wr_s && (lbs_addr == ADDR_KICK);
  assign tout_wr_s  = wr_s && (lbs_addr == ADDR_TOUT);
  assign flag_clr_s = wr_s && (lbs_addr == ADDR_WFLAG) && lbs_din[0];
  // Flag fires only on the tick that moves the counter onto the timeout;
  // a kick or timeout rewrite in that cycle suppresses it
  assign flag_set_s = tick_s && !kick_s && !tout_wr_s && (tout_r != 16'h0000) &&
                      (hb_r < tout_r) && ((hb_r + 16'h0001) == tout_r);

  // Tick prescaler, restarted by a kick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
    end else if (kick_s || tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Heartbeat counter, saturating at the programmed timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_r <= 16'h0000;
    end else if (kick_s || tout_wr_s || (tout_r == 16'h0000)) begin
      hb_r <= 16'h0000;
    end else if (tick_s && (hb_r < tout_r)) begin
      hb_r <= hb_r + 16'h0001;
    end else begin
      hb_r <= hb_r;
    end
  end

  // Timeout register and sticky flag (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_r <= 16'h0002;
      flag_r <= 1'b0;
    end else begin
      if (tout_wr_s) begin
        tout_r <= lbs_din;
      end else begin
        tout_r <= tout_r;
      end
      if (flag_set_s) begin
        flag_r <= 1'b1;
      end else if (flag_clr_s) begin
        flag_r <= 1'b0;
      end else begin
        flag_r <= flag_r;
      end
    end
  end

  assign wdt_timeout = flag_r;
`else
  assign wdt_timeout = 1'b0;
`endif

  // Read multiplexer; narrow fields are zero-extended
  always_comb begin
    rdata_s = 16'h0000;
    case (lbs_addr)
      ADDR_VER0: rdata_s = LOGIC_VER_YEAR;
      ADDR_VER1: rdata_s = LOGIC_VER_MONTH_DAY;
      ADDR_VER2: rdata_s = LOGIC_VER;
      ADDR_VER3: rdata_s = DEBUG_VER;
      ADDR_TEST: rdata_s = ~test_r;
      ADDR_RAW:  rdata_s[INT_CH-1:0] = active_s;
      ADDR_PEND: rdata_s[INT_CH-1:0] = pend_r;
      ADDR_MASK: rdata_s[INT_CH-1:0] = mask_r;
      ADDR_MODE: rdata_s[INT_CH-1:0] = mode_r;
      ADDR_POL:  rdata_s[INT_CH-1:0] = pol_r;
      ADDR_EN:   rdata_s[0] = en_r;
`ifdef SYS_INT_REGS_HB_WDT_EN
      ADDR_TOUT:  rdata_s = tout_r;
      ADDR_WFLAG: rdata_s[0] = flag_r;
`endif
      default:   rdata_s = 16'h0000;
    endcase
  end

  // Registered read data, held between read strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lbs_dout <= 16'h0000;
    end else if (rd_s) begin
      lbs_dout <= rdata_s;
    end else begin
      lbs_dout <= lbs_dout;
    end
  end

endmodule
